// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit seven-segment scanner.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  // Active-low cathode patterns {g,f,e,d,c,b,a} for hex digits 0..F.
  localparam logic [0:15][6:0] SEG_TABLE = {
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // One full display image: four nibbles, per-digit dp and blank masks.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Straight table lookup; the table lives in the package.
  always_comb begin
    seg = SEG_TABLE[nib];
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// New data is double-buffered (pending -> active) and only swapped at the
// frame boundary so a frame never mixes old and new digits.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int NUM_DIGITS  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  input  logic        load,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam digit_idx_t    LAST_DIG  = digit_idx_t'(NUM_DIGITS - 1);

  logic [PW-1:0] presc_q, presc_d;
  digit_idx_t    dig_q, dig_d;
  disp_t         pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  disp_t         act_q, act_d;
  logic [1:0]    bnd_pipe_q, bnd_pipe_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  logic          tick;
  logic          boundary;
  disp_t         in_img;
  logic [3:0]    nib;
  logic [6:0]    dec_seg;

  assign in_img   = '{value: value, dp: dp_in, blank: blank};
  assign tick     = (presc_q == PRESC_MAX);
  assign boundary = tick && (dig_q == LAST_DIG);

  // Prescaler and digit index: one digit slot every REFRESH_DIV clocks.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    dig_d   = tick ? digit_idx_t'(dig_q + 2'd1) : dig_q;
  end

  // Double buffer: loads land in pending, pending moves to active only at
  // the frame boundary; a load in the boundary cycle bypasses pending.
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    act_d      = act_q;
    if (boundary) begin
      if (load)            act_d = in_img;
      else if (pend_vld_q) act_d = pend_q;
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_d     = in_img;
      pend_vld_d = 1'b1;
    end
  end

  // Nibble selected ahead of the decoder; outputs registered behind it.
  always_comb begin
    nib = act_q.value[{dig_q, 2'b00} +: 4];
  end

  hex_to_seg7 u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  // Next output image for the current slot, dark when blanked.
  always_comb begin
    if (act_q.blank[dig_q]) begin
      an_d  = 4'hF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = dec_seg;
      dp_d  = ~act_q.dp[dig_q];
    end
  end

  // Boundary delayed two clocks so frame_done lines up with digit 0 on an.
  always_comb begin
    bnd_pipe_d = {bnd_pipe_q[0], boundary};
  end

  // All state, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      dig_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      act_q      <= '0;
      bnd_pipe_q <= '0;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      an_q       <= 4'hF;
    end else begin
      presc_q    <= presc_d;
      dig_q      <= dig_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      act_q      <= act_d;
      bnd_pipe_q <= bnd_pipe_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = bnd_pipe_q[1];

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with REFRESH_DIV=4 (16-cycle frames).
module tb_seg7_scan;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  seg7_scan #(.REFRESH_DIV(RD), .NUM_DIGITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .blank      (blank),
    .load       (load),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Decode table written out from the digit glyph list.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: c counts clocks since reset release; each digit slot is
  // RD clocks, a frame is 4*RD. The image in use for the shown slot is the
  // one active before the most recent clock.
  int          c;
  logic [23:0] act_m, act_prev, pend_m;  // {value, dp, blank}
  bit          pv;

  task automatic model_reset();
    c = 0; act_m = '0; act_prev = '0; pend_m = '0; pv = 0;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s c=%0d got=%h exp=%h", tag, c, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [3:0] e_an; logic [6:0] e_seg; logic e_dp, e_fd;
    int d;
    logic [15:0] v; logic [3:0] dm, bm;
    if (c == 0) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      d = ((c - 1) / RD) % 4;
      {v, dm, bm} = act_prev;
      if (bm[d]) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an  = 4'hF & ~(4'(1) << d);
        e_seg = glyph[(v >> (4 * d)) & 16'hF];
        e_dp  = ~dm[d];
      end
      e_fd = (c > 4 * RD) && (c % (4 * RD) == 1);
    end
    chk("an",  {4'h0, an},  {4'h0, e_an});
    chk("seg", {1'b0, seg}, {1'b0, e_seg});
    chk("dp",  {7'h0, dp},  {7'h0, e_dp});
    chk("frame_done", {7'h0, frame_done}, {7'h0, e_fd});
  endtask

  // One clock: drive inputs, advance model on the edge, check on the negedge.
  task automatic cyc(input bit ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    bit bnd;
    load = ld; value = v; dp_in = d; blank = b;
    @(posedge clk);
    if (rst_n) begin
      bnd = (c % (4 * RD)) == (4 * RD - 1);
      act_prev = act_m;
      if (bnd) begin
        if (ld) act_m = {v, d, b};
        else if (pv) act_m = pend_m;
        pv = 0;
      end else if (ld) begin
        pend_m = {v, d, b};
        pv = 1;
      end
      c++;
    end
    @(negedge clk);
    load = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, value, dp_in, blank);
  endtask

  // Idle until the model sits at the given position within the frame.
  task automatic idle_to(input int pos);
    int guard = 0;
    while ((c % (4 * RD)) != pos && guard < 64) begin
      cyc(1'b0, value, dp_in, blank);
      guard++;
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank = '0;
    model_reset();
    @(negedge clk);

    // Held in reset: dark outputs throughout.
    for (int i = 0; i < 10; i++) cyc(1'b1, 16'hFFFF, 4'hF, 4'h0);

    // Release and show "0000".
    rst_n = 1'b1;
    idle(3);

    // First image; lands at the first boundary.
    cyc(1'b1, 16'hF8D7, 4'b0010, 4'b0000);
    idle(36);

    // Mid-frame load must not tear the current frame.
    idle_to(6);
    cyc(1'b1, 16'h1234, 4'b0000, 4'b0000);
    idle(30);

    // Two loads in one frame: latest wins.
    idle_to(2);
    cyc(1'b1, 16'hAAAA, 4'b1111, 4'b0000);
    idle(3);
    cyc(1'b1, 16'h5555, 4'b0000, 4'b0000);
    idle(30);

    // Load in the boundary cycle goes straight to active, with blanking.
    idle_to(15);
    cyc(1'b1, 16'hCCCC, 4'b0000, 4'b0101);
    idle(20);

    // Pending load discarded by an asynchronous reset during digit 2.
    idle_to(8);
    cyc(1'b1, 16'h9999, 4'b1111, 4'b0000);
    idle(1);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs();
    idle(3);
    rst_n = 1'b1;
    idle(40);

    // Randomized loads with random images.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) == 0), 16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
